// File: rtl/sobel_pkg.sv
// Shared constants and types for the Sobel line-buffer slice.
// Pixel width, default image size and line-buffer FSM encoding.
package sobel_pkg;

    localparam int DEF_DW   = 8;
    localparam int DEF_ROWS = 512;
    localparam int DEF_COLS = 512;

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } lb_state_t;

endpackage

// File: rtl/sobel_line_ram.sv
// One image line of pixels, indexed by column.
// Registered write port, combinational read port.
module sobel_line_ram
    import sobel_pkg::*;
#(
    parameter int COLS = DEF_COLS,
    parameter int DW   = DEF_DW,
    localparam int AW  = $clog2(COLS)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [COLS];

    // Write one pixel per enabled cycle.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/sobel_line_buffer.sv
// Raster pixel stream to vertical 3-pixel columns for the Sobel stage.
// lineA holds row r-1, lineB holds row r; flush drains the last centre row.
module sobel_line_buffer
    import sobel_pkg::*;
#(
    parameter int ROWS = DEF_ROWS,
    parameter int COLS = DEF_COLS,
    parameter int DW   = DEF_DW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] pix_i,
    input  logic          valid_i,
    output logic          ready_o,
    output logic [DW-1:0] d0_o,
    output logic [DW-1:0] d1_o,
    output logic [DW-1:0] d2_o,
    output logic          done_o,
    output logic          frame_done_o
);

    localparam int CW = $clog2(COLS);
    localparam int RW = $clog2(ROWS);
    localparam logic [CW-1:0] COL_LAST = CW'(COLS - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);
    localparam logic [RW-1:0] ROW_ONE  = RW'(1);

    lb_state_t state, state_nx;

    logic [CW-1:0] in_col;
    logic [RW-1:0] in_row;
    logic [CW-1:0] out_col;
    logic [CW-1:0] rd_addr;
    logic [DW-1:0] a_rd;
    logic [DW-1:0] b_rd;
    logic          xfer;
    logic          col_last;
    logic          row_last;
    logic          flush_last;

    // Input is held off through the flush and its final strobe cycle.
    assign ready_o    = ~rst & (state != FLUSH) & ~frame_done_o;
    assign xfer       = valid_i & ready_o;
    assign col_last   = (in_col == COL_LAST);
    assign row_last   = (in_row == ROW_LAST);
    assign flush_last = (out_col == COL_LAST);
    assign rd_addr    = (state == FLUSH) ? out_col : in_col;

    sobel_line_ram #(
        .COLS (COLS),
        .DW   (DW)
    ) u_line_a (
        .clk   (clk),
        .we    (xfer && (state == RUN)),
        .waddr (in_col),
        .wdata (b_rd),
        .raddr (rd_addr),
        .rdata (a_rd)
    );

    sobel_line_ram #(
        .COLS (COLS),
        .DW   (DW)
    ) u_line_b (
        .clk   (clk),
        .we    (xfer),
        .waddr (in_col),
        .wdata (pix_i),
        .raddr (rd_addr),
        .rdata (b_rd)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= FILL;
        end else begin
            state <= state_nx;
        end
    end

    // Next state: fill row 0, run remaining rows, then drain one row.
    always_comb begin
        state_nx = state;
        unique case (state)
            FILL: begin
                if (xfer && col_last) begin
                    state_nx = RUN;
                end
            end
            RUN: begin
                if (xfer && col_last && row_last) begin
                    state_nx = FLUSH;
                end
            end
            FLUSH: begin
                if (flush_last) begin
                    state_nx = FILL;
                end
            end
            default: state_nx = FILL;
        endcase
    end

    // Raster position of the input stream and the flush column.
    always_ff @(posedge clk) begin
        if (rst) begin
            in_col  <= '0;
            in_row  <= '0;
            out_col <= '0;
        end else begin
            if (xfer) begin
                if (col_last) begin
                    in_col <= '0;
                    in_row <= row_last ? '0 : in_row + 1'b1;
                end else begin
                    in_col <= in_col + 1'b1;
                end
            end
            if (state == FLUSH) begin
                out_col <= flush_last ? '0 : out_col + 1'b1;
            end
        end
    end

    // Output column registers; data holds while no strobe is issued.
    always_ff @(posedge clk) begin
        if (rst) begin
            d0_o         <= '0;
            d1_o         <= '0;
            d2_o         <= '0;
            done_o       <= 1'b0;
            frame_done_o <= 1'b0;
        end else begin
            done_o       <= 1'b0;
            frame_done_o <= 1'b0;
            if ((state == RUN) && xfer) begin
                done_o <= 1'b1;
                d0_o   <= pix_i;
                d1_o   <= b_rd;
                d2_o   <= (in_row == ROW_ONE) ? '0 : a_rd;
            end else if (state == FLUSH) begin
                done_o       <= 1'b1;
                d0_o         <= '0;
                d1_o         <= b_rd;
                d2_o         <= a_rd;
                frame_done_o <= flush_last;
            end
        end
    end

endmodule

// File: tb/tb_sobel_line_buffer.sv
// Scoreboard bench for sobel_line_buffer on a 4x5 image.
// Expected columns come from a whole-image model of each frame.
module tb_sobel_line_buffer;

    localparam int R  = 4;
    localparam int C  = 5;
    localparam int DW = 8;

    typedef logic [3*DW:0] exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] pix_i = '0;
    logic          valid_i = 1'b0;
    logic          ready_o;
    logic [DW-1:0] d0_o, d1_o, d2_o;
    logic          done_o, frame_done_o;

    exp_t sb[$];
    exp_t cap[$];
    bit   cap_on = 1'b0;
    bit   run_flag = 1'b0;
    int   img[R][C];
    int   n_checks = 0;
    int   n_pass = 0;

    sobel_line_buffer #(
        .ROWS (R),
        .COLS (C),
        .DW   (DW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .pix_i        (pix_i),
        .valid_i      (valid_i),
        .ready_o      (ready_o),
        .d0_o         (d0_o),
        .d1_o         (d1_o),
        .d2_o         (d2_o),
        .done_o       (done_o),
        .frame_done_o (frame_done_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic send_frame(input int base, input bit rnd,
                              input int gap_pct, input int n_xfer);
        int d0, d2;
        for (int r = 0; r < R; r++)
            for (int c = 0; c < C; c++)
                img[r][c] = rnd ? int'($urandom_range(0, 255))
                                : base + 10 * r + c;
        for (int r = 0; r < R; r++)
            for (int c = 0; c < C; c++) begin
                d0 = (r < R - 1) ? img[r+1][c] : 0;
                d2 = (r > 0) ? img[r-1][c] : 0;
                sb.push_back({(r == R-1 && c == C-1), 8'(d0),
                              8'(img[r][c]), 8'(d2)});
            end
        for (int i = 0; i < n_xfer; i++) begin
            bit acc;
            acc = 1'b0;
            while (!acc) begin
                @(negedge clk);
                if (gap_pct > 0 && int'($urandom_range(0, 99)) < gap_pct) begin
                    valid_i = 1'b0;
                    @(posedge clk);
                end else begin
                    valid_i = 1'b1;
                    pix_i   = 8'(img[i/C][i%C]);
                    acc     = ready_o;
                    @(posedge clk);
                    if (acc && i >= C) run_flag = 1'b1;
                end
            end
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 100 && sb.size() > 0; i++) @(negedge clk);
        repeat (2) @(negedge clk);
        chk("drain_left", sb.size(), 0);
        sb.delete();
    endtask

    // Monitor: strobe timing and scoreboard comparison.
    always @(negedge clk) begin
        if (!rst) begin
            if (run_flag) begin
                chk("latency", int'(done_o), 1);
                run_flag = 1'b0;
            end else if (done_o) begin
                chk("flush_ready", int'(ready_o), 0);
            end
            if (done_o) begin
                exp_t e;
                if (cap_on) cap.push_back({frame_done_o, d0_o, d1_o, d2_o});
                if (sb.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_strobe: got d1=%0d expected none",
                             d1_o);
                end else begin
                    e = sb.pop_front();
                    chk("d0", int'(d0_o), int'(e[23:16]));
                    chk("d1", int'(d1_o), int'(e[15:8]));
                    chk("d2", int'(d2_o), int'(e[7:0]));
                    chk("frame_done", int'(frame_done_o), int'(e[24]));
                end
            end
        end
    end

    initial begin
        repeat (20000) @(posedge clk);
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", int'(ready_o), 0);
        chk("rst_done", int'(done_o), 0);
        chk("rst_fdone", int'(frame_done_o), 0);
        chk("rst_data", int'({d0_o, d1_o, d2_o}), 0);
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", int'(ready_o), 1);

        cap_on = 1'b1;
        send_frame(0, 1'b0, 0, R*C);
        send_frame(100, 1'b0, 0, R*C);
        @(negedge clk);
        valid_i = 1'b0;
        drain();
        cap_on = 1'b0;
        chk("strobe_count", cap.size(), 2*R*C);
        if (cap.size() == 2*R*C) begin
            chk("first_out", int'(cap[0]), int'({1'b0, 8'd10, 8'd0, 8'd0}));
            chk("r1c4", int'(cap[9]), int'({1'b0, 8'd24, 8'd14, 8'd4}));
            chk("r2c3", int'(cap[13]), int'({1'b0, 8'd33, 8'd23, 8'd13}));
            chk("last_out", int'(cap[19]), int'({1'b1, 8'd0, 8'd34, 8'd24}));
            chk("f2_first", int'(cap[20]), int'({1'b0, 8'd110, 8'd100, 8'd0}));
        end

        send_frame(0, 1'b0, 50, R*C);
        @(negedge clk);
        valid_i = 1'b0;
        drain();
        send_frame(0, 1'b1, 50, R*C);
        send_frame(0, 1'b1, 30, R*C);
        @(negedge clk);
        valid_i = 1'b0;
        drain();

        send_frame(0, 1'b1, 0, 2*C + 2);
        @(negedge clk);
        valid_i = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_ready", int'(ready_o), 0);
        chk("mid_rst_done", int'(done_o), 0);
        chk("mid_rst_data", int'({d0_o, d1_o, d2_o}), 0);
        sb.delete();
        run_flag = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_ready_rel", int'(ready_o), 1);
        send_frame(0, 1'b0, 0, R*C);
        @(negedge clk);
        valid_i = 1'b0;
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
